// File: rtl/delay_pkg.sv
// Shared types and helpers for the RAM-based variable delay line.
// State enum, delay clamping and modular ring-pointer subtraction.
package delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Legal delays are 1..m; zero and oversize requests are pulled in.
  function automatic int unsigned dly_clamp(
    input int unsigned value,
    input int unsigned m
  );
    if (value == 0) return 1;
    if (value > m) return m;
    return value;
  endfunction

  // (ptr - d) mod m without a divider; m need not be a power of two.
  function automatic int unsigned ring_sub(
    input int unsigned ptr,
    input int unsigned d,
    input int unsigned m
  );
    if (ptr >= d) return ptr - d;
    return ptr + m - d;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port a write-only, port b read-only, read-first.
// Ports: clk, wea/addra/dina (write), enb/addrb (read), qb (read data).
module dpram #(
  parameter int    DWIDTH = 16,
  parameter int    AWIDTH = 10,
  parameter string REGIN  = "N",
  parameter string REGOUT = "Y"
) (
  input  logic              clk,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  input  logic              enb,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] qb
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              we;
  logic [AWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;
  logic              re;
  logic [AWIDTH-1:0] ra;

  if (REGIN == "Y") begin : g_regin
    always_ff @(posedge clk) begin
      we <= wea;
      wa <= addra;
      wd <= dina;
      re <= enb;
      ra <= addrb;
    end
  end else begin : g_nregin
    assign we = wea;
    assign wa = addra;
    assign wd = dina;
    assign re = enb;
    assign ra = addrb;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Non-blocking update of mem makes a same-address read see old data.
  if (REGOUT == "Y") begin : g_regout
    always_ff @(posedge clk) begin
      if (re) qb <= mem[ra];
    end
  end else begin : g_nregout
    assign qb = mem[ra];
  end

endmodule

// File: rtl/vardelayram.sv
// Runtime-programmable RAM delay line with history-gated output.
// Ports: clk, rst, ena/data in, dly/dly_ld load, delay/vld/clamp/cur_dly out.
module vardelayram
  import delay_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int MAXDELAY = 1024,
  parameter  int DEFDELAY = 1,
  localparam int AW       = $clog2(MAXDELAY),
  localparam int DW       = $clog2(MAXDELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] data,
  input  logic [DW-1:0]    dly,
  input  logic             dly_ld,
  output logic [WIDTH-1:0] delay,
  output logic             vld,
  output logic             clamp,
  output logic [DW-1:0]    cur_dly
);

  if (WIDTH < 1) begin : g_bad_width
    $error("vardelayram: WIDTH must be nonzero");
  end
  if (MAXDELAY < 2) begin : g_bad_max
    $error("vardelayram: MAXDELAY must be at least 2");
  end
  if (DEFDELAY < 1 || DEFDELAY > MAXDELAY) begin : g_bad_def
    $error("vardelayram: DEFDELAY out of 1..MAXDELAY");
  end

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     wptr_nx;
  logic [AW-1:0]     raddr;
  logic [DW-1:0]     hist;
  logic [DW-1:0]     hist_nx;
  logic [DW-1:0]     d_ld;
  logic [DW-1:0]     d_eff;
  logic              qual;
  logic              qual_q;
  logic              acc;
  logic [WIDTH-1:0]  q;

  assign acc = ena & ~rst;

  always_comb begin
    d_ld     = DW'(dly_clamp(32'(dly), MAXDELAY));
    d_eff    = dly_ld ? d_ld : cur_dly;
    // RUN already encodes hist >= cur_dly; a load needs a fresh compare.
    qual     = dly_ld ? (hist >= d_ld) : (state == RUN);
    raddr    = AW'(ring_sub(32'(wptr), 32'(d_eff), MAXDELAY));
    wptr_nx  = wptr;
    hist_nx  = hist;
    if (ena) begin
      if (wptr == AW'(MAXDELAY - 1)) wptr_nx = '0;
      else wptr_nx = wptr + 1'b1;
      if (hist != DW'(MAXDELAY)) hist_nx = hist + 1'b1;
    end
    state_nx = (hist_nx >= d_eff) ? RUN : FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      wptr    <= '0;
      hist    <= '0;
      cur_dly <= DW'(DEFDELAY);
      qual_q  <= 1'b0;
      vld     <= 1'b0;
      clamp   <= 1'b0;
    end else begin
      state   <= state_nx;
      wptr    <= wptr_nx;
      hist    <= hist_nx;
      vld     <= ena & qual;
      clamp   <= dly_ld & (d_ld != dly);
      if (dly_ld) cur_dly <= d_ld;
      if (ena) qual_q <= qual;
    end
  end

  dpram #(
    .DWIDTH (WIDTH),
    .AWIDTH (AW),
    .REGIN  ("N"),
    .REGOUT ("Y")
  ) u_ram (
    .clk   (clk),
    .wea   (acc),
    .addra (wptr),
    .dina  (data),
    .enb   (acc),
    .addrb (raddr),
    .qb    (q)
  );

  // q only moves on accepted samples, so delay holds across ena gaps.
  assign delay = qual_q ? q : '0;

endmodule

// File: tb/tb_vardelayram.sv
// Directed table-driven bench for vardelayram (M=8) plus a gapped
// stream with mid-stream reset checked against a sample-history model.
module tb_vardelayram;

  localparam int W  = 16;
  localparam int M  = 8;
  localparam int DW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [W-1:0]  data;
  logic [DW-1:0] dly;
  logic          dly_ld;
  logic [W-1:0]  delay;
  logic          vld;
  logic          clamp;
  logic [DW-1:0] cur_dly;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vardelayram #(
    .WIDTH    (W),
    .MAXDELAY (M),
    .DEFDELAY (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .data    (data),
    .dly     (dly),
    .dly_ld  (dly_ld),
    .delay   (delay),
    .vld     (vld),
    .clamp   (clamp),
    .cur_dly (cur_dly)
  );

  typedef struct {
    bit r;
    bit e;
    int d;
    int dl;
    bit ld;
    bit ev;
    int ed;
    bit ec;
    int ecur;
  } vec_t;

  vec_t tbl[$];

  task automatic v(bit r, bit e, int d, int dl, bit ld,
                   bit ev, int ed, bit ec, int ecur);
    vec_t x;
    x.r = r; x.e = e; x.d = d; x.dl = dl; x.ld = ld;
    x.ev = ev; x.ed = ed; x.ec = ec; x.ecur = ecur;
    tbl.push_back(x);
  endtask

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d",
               name, idx, act, exp);
    end
  endtask

  task automatic drive(bit r, bit e, int d, int dl, bit ld);
    rst    = r;
    ena    = e;
    data   = W'(d);
    dly    = DW'(dl);
    dly_ld = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hq[$];
    int mD;
    int held;
    bit ev;
    bit e;
    bit r;
    bit ld;

    rst = 1'b1; ena = 1'b0; data = '0; dly = '0; dly_ld = 1'b0;

    // Default delay 1
    v(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 12; i++)
      v(0, 1, i, 0, 0, i >= 2, (i >= 2) ? i - 1 : 0, 0, 1);

    // D = M, read-first at wrap
    v(1, 0, 0, 0, 0, 0, 0, 0, 1);
    v(0, 0, 0, 8, 1, 0, 0, 0, 8);
    for (int k = 1; k <= 20; k++)
      v(0, 1, k, 0, 0, k >= 9, (k >= 9) ? k - 8 : 0, 0, 8);

    // Shrink / grow within history: no gap
    v(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++)
      v(0, 1, k, 3, k == 1, k >= 4, (k >= 4) ? k - 3 : 0, 0, 3);
    v(0, 1, 11, 2, 1, 1, 9, 0, 2);
    v(0, 1, 12, 6, 1, 1, 6, 0, 6);
    v(0, 1, 13, 0, 0, 1, 7, 0, 6);

    // Grow past history: back to FILL
    v(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++)
      v(0, 1, k, 2, k == 1, k >= 3, (k >= 3) ? k - 2 : 0, 0, 2);
    v(0, 1, 5, 5, 1, 0, 0, 0, 5);
    v(0, 1, 6, 0, 0, 1, 1, 0, 5);
    v(0, 1, 7, 0, 0, 1, 2, 0, 5);

    // Clamping, delay holds 2 while idle
    v(0, 0, 0, 0, 1, 0, 2, 1, 1);
    v(0, 0, 0, 0, 0, 0, 2, 0, 1);
    v(0, 0, 0, 11, 1, 0, 2, 1, 8);
    v(0, 0, 0, 0, 0, 0, 2, 0, 8);
    v(0, 0, 0, 4, 1, 0, 2, 0, 4);
    v(0, 0, 0, 8, 1, 0, 2, 0, 8);
    v(0, 0, 0, 0, 0, 0, 2, 0, 8);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].dl, tbl[i].ld);
      chk("vld", i, int'(vld), int'(tbl[i].ev));
      chk("delay", i, int'(delay), tbl[i].ed);
      chk("clamp", i, int'(clamp), int'(tbl[i].ec));
      chk("cur_dly", i, int'(cur_dly), tbl[i].ecur);
    end

    // Gapped stream with mid-stream reset
    drive(1, 0, 0, 0, 0);
    chk("g_rst_vld", 0, int'(vld), 0);
    chk("g_rst_cur", 0, int'(cur_dly), 1);
    mD = 1;
    held = 0;
    for (int c = 0; c < 48; c++) begin
      r  = (c == 24);
      ld = (c == 0) || (c == 25);
      e  = 1'($urandom_range(0, 1));
      drive(r, e, 100 + c, 3, ld);
      ev = 1'b0;
      if (r) begin
        hq.delete();
        held = 0;
        mD = 1;
      end else begin
        if (ld) mD = 3;
        if (e) begin
          if (hq.size() >= mD) begin
            ev = 1'b1;
            held = hq[hq.size() - mD];
          end else begin
            held = 0;
          end
          hq.push_back(100 + c);
        end
      end
      chk("g_vld", c, int'(vld), int'(ev));
      chk("g_delay", c, int'(delay), held);
      chk("g_cur", c, int'(cur_dly), mD);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
